// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Widths: XLEN data bits, AW address bits (NREG = 2^AW registers, x0 reads as zero).
// Requester indices: REQ_A (ALU result), REQ_M (load result).
// wbReq_t is the payload of one holding slot.
package regfile_wb_arbiter_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NREG  = 1 << AW;
  localparam int unsigned CNT_W = 32;

  localparam int unsigned REQ_A = 0;
  localparam int unsigned REQ_M = 1;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wbReq_t;

  // Round-robin pointer: the side that wins when both slots hold a write.
  typedef enum logic {
    PTR_A = 1'b0,
    PTR_M = 1'b1
  } rrPtr_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register file.
// slave modport  : arbiter side (takes requests, drives Ready and the write port).
// master modport : requester / register-file side.
// Signals: AValid/AReady/AAddr/AData, MValid/MReady/MAddr/MData,
//          RegWEn/AddrD/DataD (register write port), PendMask (pending writes).
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic            AValid;
  logic            AReady;
  logic [AW-1:0]   AAddr;
  logic [XLEN-1:0] AData;

  logic            MValid;
  logic            MReady;
  logic [AW-1:0]   MAddr;
  logic [XLEN-1:0] MData;

  logic            RegWEn;
  logic [AW-1:0]   AddrD;
  logic [XLEN-1:0] DataD;
  logic [NREG-1:0] PendMask;

  modport slave (
    input  AValid, AAddr, AData,
    input  MValid, MAddr, MData,
    output AReady, MReady,
    output RegWEn, AddrD, DataD, PendMask
  );

  modport master (
    output AValid, AAddr, AData,
    output MValid, MAddr, MData,
    input  AReady, MReady,
    input  RegWEn, AddrD, DataD, PendMask
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// One-entry writeback holding slot for a single requester.
// Ports: clk, rst (sync, active-high); reqValid/reqAddr/reqData request in;
//        granted (slot is being written this cycle); reqReady_c (combinational
//        ready, never a function of reqValid); slot (registered contents).
// Writes to x0 are accepted but dropped so they never reach the register file.
module regfile_wb_arbiter_wb_slot
  import regfile_wb_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            reqValid,
  input  logic [AW-1:0]   reqAddr,
  input  logic [XLEN-1:0] reqData,
  input  logic            granted,
  output logic            reqReady_c,
  output wbReq_t          slot
);

  wbReq_t slotQ;

  // Free now, or draining this cycle so it can be refilled at the same edge.
  assign reqReady_c = !slotQ.valid || granted;
  assign slot       = slotQ;

  // Load on a non-x0 transfer; otherwise clear once the held write is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      slotQ <= '0;
    end else if (reqValid && reqReady_c && (reqAddr != '0)) begin
      slotQ <= '{valid: 1'b1, addr: reqAddr, data: reqData};
    end else if (granted) begin
      slotQ <= '0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU (A) and load (M)
// writeback paths. Each path has a one-entry slot; a round-robin arbiter drains
// them one write per cycle and PendMask flags registers with a write in flight.
// Ports: CLK, RST (sync, active-high); bus (regfile_wb_arbiter_if.slave).
// Optional: define WBARB_STATS_EN to add ConflictCnt[31:0] (cycles with both
// slots valid) and WriteCnt[31:0] (RegWEn cycles); both wrap and clear on RST.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input logic                 CLK,
  input logic                 RST,
  regfile_wb_arbiter_if.slave bus
`ifdef WBARB_STATS_EN
  ,
  output logic [CNT_W-1:0]    ConflictCnt,
  output logic [CNT_W-1:0]    WriteCnt
`endif
);

  wbReq_t          slotA;
  wbReq_t          slotM;
  logic            grantA;
  logic            grantM;
  logic            grantValid;
  rrPtr_t          rrPtr;
  rrPtr_t          rrPtrNext;
  logic [NREG-1:0] pendMask;

  regfile_wb_arbiter_wb_slot uSlotA (
    .clk        (CLK),
    .rst        (RST),
    .reqValid   (bus.AValid),
    .reqAddr    (bus.AAddr),
    .reqData    (bus.AData),
    .granted    (grantA),
    .reqReady_c (bus.AReady),
    .slot       (slotA)
  );

  regfile_wb_arbiter_wb_slot uSlotM (
    .clk        (CLK),
    .rst        (RST),
    .reqValid   (bus.MValid),
    .reqAddr    (bus.MAddr),
    .reqData    (bus.MData),
    .granted    (grantM),
    .reqReady_c (bus.MReady),
    .slot       (slotM)
  );

  // Grant straight from slot registers; pointer only breaks ties.
  always_comb begin
    grantA     = slotA.valid && (!slotM.valid || (rrPtr == PTR_A));
    grantM     = slotM.valid && (!slotA.valid || (rrPtr == PTR_M));
    grantValid = slotA.valid || slotM.valid;
  end

  // Round-robin pointer register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rrPtr <= PTR_A;
    end else begin
      rrPtr <= rrPtrNext;
    end
  end

  // Pointer flips to the other side after every grant.
  always_comb begin
    rrPtrNext = rrPtr;
    case (rrPtr)
      PTR_A:   if (grantA) rrPtrNext = PTR_M;
               else if (grantM) rrPtrNext = PTR_A;
      PTR_M:   if (grantM) rrPtrNext = PTR_A;
               else if (grantA) rrPtrNext = PTR_M;
      default: rrPtrNext = PTR_A;
    endcase
  end

  // Write port; suppressed while RST is high so a pending write is never
  // committed at the reset edge.
  always_comb begin
    bus.RegWEn = 1'b0;
    bus.AddrD  = '0;
    bus.DataD  = '0;
    if (grantValid && !RST) begin
      bus.RegWEn = 1'b1;
      if (grantA) begin
        bus.AddrD = slotA.addr;
        bus.DataD = slotA.data;
      end else begin
        bus.AddrD = slotM.addr;
        bus.DataD = slotM.data;
      end
    end
  end

  // Pending-write mask: OR of decoded addresses of valid slots.
  always_comb begin
    pendMask = '0;
    if (slotA.valid) pendMask[slotA.addr] = 1'b1;
    if (slotM.valid) pendMask[slotM.addr] = 1'b1;
  end

  assign bus.PendMask = pendMask;

`ifdef WBARB_STATS_EN
  // Contention and write statistics.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ConflictCnt <= '0;
      WriteCnt    <= '0;
    end else begin
      if (slotA.valid && slotM.valid) ConflictCnt <= ConflictCnt + CNT_W'(1);
      if (bus.RegWEn)                 WriteCnt    <= WriteCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, round-robin
// contention, shared destination, x0 filtering, reset with full slots and a
// saturated run checked against a scoreboard of accepted writes.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  regfile_wb_arbiter_if bus ();

`ifdef WBARB_STATS_EN
  logic [31:0] conflictCnt;
  logic [31:0] writeCnt;
`endif

  regfile_wb_arbiter dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus)
`ifdef WBARB_STATS_EN
    ,
    .ConflictCnt (conflictCnt),
    .WriteCnt    (writeCnt)
`endif
  );

  int checkCnt = 0;
  int errCnt   = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic idleInputs();
    bus.AValid = 1'b0;
    bus.AAddr  = '0;
    bus.AData  = '0;
    bus.MValid = 1'b0;
    bus.MAddr  = '0;
    bus.MData  = '0;
  endtask

  task automatic checkIdle(input string tag);
    checkVal({tag, "_wen"},  64'(bus.RegWEn),   64'(0));
    checkVal({tag, "_addr"}, 64'(bus.AddrD),    64'(0));
    checkVal({tag, "_data"}, 64'(bus.DataD),    64'(0));
    checkVal({tag, "_pend"}, 64'(bus.PendMask), 64'(0));
  endtask

  task automatic checkWrite(input string tag, input logic [AW-1:0] addr,
                            input logic [XLEN-1:0] data, input logic [NREG-1:0] mask);
    checkVal({tag, "_wen"},  64'(bus.RegWEn),   64'(1));
    checkVal({tag, "_addr"}, 64'(bus.AddrD),    64'(addr));
    checkVal({tag, "_data"}, 64'(bus.DataD),    64'(data));
    checkVal({tag, "_pend"}, 64'(bus.PendMask), 64'(mask));
  endtask

  // Present A and M in the same cycle and check the two resulting writes in order.
  task automatic contend(input string tag,
                         input logic [AW-1:0] aAddr, input logic [XLEN-1:0] aData,
                         input logic [AW-1:0] mAddr, input logic [XLEN-1:0] mData,
                         input logic mFirst);
    logic [NREG-1:0] both;
    both = '0;
    both[aAddr] = 1'b1;
    both[mAddr] = 1'b1;
    nextCycle();
    bus.AValid = 1'b1; bus.AAddr = aAddr; bus.AData = aData;
    bus.MValid = 1'b1; bus.MAddr = mAddr; bus.MData = mData;
    sample();
    checkVal({tag, "_aready"}, 64'(bus.AReady), 64'(1));
    checkVal({tag, "_mready"}, 64'(bus.MReady), 64'(1));
    nextCycle();
    idleInputs();
    sample();
    if (mFirst) begin
      checkWrite({tag, "_w1"}, mAddr, mData, both);
      checkVal({tag, "_w1_aready"}, 64'(bus.AReady), 64'(0));
      checkVal({tag, "_w1_mready"}, 64'(bus.MReady), 64'(1));
    end else begin
      checkWrite({tag, "_w1"}, aAddr, aData, both);
      checkVal({tag, "_w1_aready"}, 64'(bus.AReady), 64'(1));
      checkVal({tag, "_w1_mready"}, 64'(bus.MReady), 64'(0));
    end
    nextCycle();
    sample();
    if (mFirst) checkWrite({tag, "_w2"}, aAddr, aData, NREG'(1) << aAddr);
    else        checkWrite({tag, "_w2"}, mAddr, mData, NREG'(1) << mAddr);
    nextCycle();
    sample();
    checkIdle({tag, "_done"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wbReq_t          qA[$];
    wbReq_t          qM[$];
    wbReq_t          head;
    logic [NREG-1:0] expMask;
    logic            aAcc;
    logic            mAcc;
    logic            done;
    int              aSent;
    int              mSent;
    int              writes;
    int unsigned     expSide;

    // Reset held two cycles while A requests; nothing may be captured.
    RST = 1'b1;
    idleInputs();
    bus.AValid = 1'b1; bus.AAddr = 5'd9; bus.AData = 32'h77;
    nextCycle();
    sample();
    checkVal("rst1_wen",  64'(bus.RegWEn),   64'(0));
    checkVal("rst1_pend", 64'(bus.PendMask), 64'(0));
    nextCycle();
    sample();
    checkVal("rst2_wen",  64'(bus.RegWEn),   64'(0));
    checkVal("rst2_pend", 64'(bus.PendMask), 64'(0));
    nextCycle();
    RST = 1'b0;
    idleInputs();
    sample();
    checkVal("post_rst_aready", 64'(bus.AReady), 64'(1));
    checkVal("post_rst_mready", 64'(bus.MReady), 64'(1));
    checkIdle("post_rst");

    // Both slots loaded at one edge, pointer at A: x3 then x7.
    contend("cont1", 5'd3, 32'hAAAA, 5'd7, 32'h5555, 1'b0);

    // Single ALU write; leaves the pointer at M.
    nextCycle();
    bus.AValid = 1'b1; bus.AAddr = 5'd5; bus.AData = 32'h16;
    sample();
    checkVal("single_aready", 64'(bus.AReady), 64'(1));
    nextCycle();
    idleInputs();
    sample();
    checkWrite("single", 5'd5, 32'h16, NREG'(1) << 5);
    nextCycle();
    sample();
    checkIdle("single_done");

    // Same contention again: pointer now at M, so x7 is written first.
    contend("cont2", 5'd3, 32'hAAAA, 5'd7, 32'h5555, 1'b1);

    // Both slots target x4; the bit stays set until the second write. Pointer at M.
    contend("samedst", 5'd4, 32'h1111, 5'd4, 32'h2222, 1'b1);

    // x0 write is accepted and dropped.
    nextCycle();
    bus.MValid = 1'b1; bus.MAddr = 5'd0; bus.MData = 32'hDEAD;
    sample();
    checkVal("x0_mready", 64'(bus.MReady), 64'(1));
    nextCycle();
    idleInputs();
    sample();
    checkIdle("x0");
    checkVal("x0_mready_after", 64'(bus.MReady), 64'(1));

`ifdef WBARB_STATS_EN
    // 7 writes so far; both slots valid together in 3 cycles.
    checkVal("stats_writes",    64'(writeCnt),    64'(7));
    checkVal("stats_conflicts", 64'(conflictCnt), 64'(3));
`endif

    // Reset with both slots full: the held writes are discarded.
    nextCycle();
    bus.AValid = 1'b1; bus.AAddr = 5'd10; bus.AData = 32'hAA;
    bus.MValid = 1'b1; bus.MAddr = 5'd11; bus.MData = 32'hBB;
    nextCycle();
    idleInputs();
    RST = 1'b1;
    sample();
    checkVal("midrst_wen",  64'(bus.RegWEn), 64'(0));
    checkVal("midrst_addr", 64'(bus.AddrD),  64'(0));
    checkVal("midrst_data", 64'(bus.DataD),  64'(0));
    nextCycle();
    RST = 1'b0;
    sample();
    checkIdle("midrst_after");
`ifdef WBARB_STATS_EN
    checkVal("midrst_writecnt",    64'(writeCnt),    64'(0));
    checkVal("midrst_conflictcnt", 64'(conflictCnt), 64'(0));
`endif

    // Saturation: 10 writes per side, both valid; grants alternate A,M,... from reset.
    aSent   = 0;
    mSent   = 0;
    writes  = 0;
    expSide = REQ_A;
    done    = 1'b0;
    nextCycle();
    bus.AValid = 1'b1; bus.AAddr = 5'($urandom_range(1, 31)); bus.AData = $urandom;
    bus.MValid = 1'b1; bus.MAddr = 5'($urandom_range(1, 31)); bus.MData = $urandom;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      sample();
      expMask = '0;
      if (qA.size() != 0) expMask[qA[0].addr] = 1'b1;
      if (qM.size() != 0) expMask[qM[0].addr] = 1'b1;
      checkVal("sat_pend", 64'(bus.PendMask), 64'(expMask));
      if (bus.RegWEn) begin
        writes++;
        if (expSide == REQ_A) begin
          if (qA.size() == 0) begin
            checkVal("sat_a_nothing_pending", 64'(1), 64'(0));
          end else begin
            head = qA.pop_front();
            checkVal("sat_a_addr", 64'(bus.AddrD), 64'(head.addr));
            checkVal("sat_a_data", 64'(bus.DataD), 64'(head.data));
          end
          expSide = REQ_M;
        end else begin
          if (qM.size() == 0) begin
            checkVal("sat_m_nothing_pending", 64'(1), 64'(0));
          end else begin
            head = qM.pop_front();
            checkVal("sat_m_addr", 64'(bus.AddrD), 64'(head.addr));
            checkVal("sat_m_data", 64'(bus.DataD), 64'(head.data));
          end
          expSide = REQ_A;
        end
      end
      aAcc = bus.AValid && bus.AReady;
      mAcc = bus.MValid && bus.MReady;
      if (aAcc) begin
        qA.push_back('{valid: 1'b1, addr: bus.AAddr, data: bus.AData});
        aSent++;
      end
      if (mAcc) begin
        qM.push_back('{valid: 1'b1, addr: bus.MAddr, data: bus.MData});
        mSent++;
      end
      done = (aSent == 10) && (mSent == 10) && (qA.size() == 0) && (qM.size() == 0);
      nextCycle();
      if (aAcc) begin
        if (aSent < 10) begin
          bus.AAddr = 5'($urandom_range(1, 31)); bus.AData = $urandom;
        end else begin
          bus.AValid = 1'b0;
        end
      end
      if (mAcc) begin
        if (mSent < 10) begin
          bus.MAddr = 5'($urandom_range(1, 31)); bus.MData = $urandom;
        end else begin
          bus.MValid = 1'b0;
        end
      end
    end
    checkVal("sat_drained", 64'(done), 64'(1));
    checkVal("sat_writes",  64'(writes), 64'(20));
    idleInputs();
    sample();
    checkIdle("sat_done");

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (RegWEn/AddrD/DataD) between two writeback requesters:
  - ALU result (A)
  - load/memory result (M)
- Each requester has a valid/ready handshake and a one-entry holding slot.
- A round-robin arbiter drains the slots, one register write per cycle.
- Exports a pending-write mask so the issue stage can stall on RAW/WAW hazards against writes not yet committed.

Parameters:
- XLEN, 32, data width of the register file.
- AW, 5, register address width (2^AW registers, x0 hardwired zero).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- AValid  in  1  ALU writeback request.
- AReady  out  1  ALU slot can accept this cycle.
- AAddr  in  AW  ALU destination register.
- AData  in  XLEN  ALU result.
- MValid  in  1  load writeback request.
- MReady  out  1  load slot can accept this cycle.
- MAddr  in  AW  load destination register.
- MData  in  XLEN  load result.
- RegWEn  out  1  register file write enable.
- AddrD  out  AW  register file write address.
- DataD  out  XLEN  register file write data.
- PendMask  out  2^AW  bit r set while a write to r is held in a slot.

Behaviour:
- Reset (RST=1 at edge):
  - both slots invalid; RR pointer = A.
  - RegWEn=0, AddrD=0, DataD=0, PendMask=0.
  - AReady/MReady=1 from the first cycle after reset.
  - Writes pending at reset are discarded, with no partial write.
- Handshake:
  - A transfer happens when Valid&&Ready at a rising edge; the slot loads {addr,data}.
  - Ready = !slot_valid || slot_granted_this_cycle.
  - Ready never depends on the same requester's Valid.
- x0 writes: Valid with Addr=0 is accepted (Ready per rule above), but the slot is not loaded; it never produces RegWEn and never sets PendMask.
- Grant:
  - Combinational from slot registers; only one slot valid → grant it.
  - Both valid → grant the RR pointer side; the pointer moves to the other side after every grant.
  - Neither valid → no grant.
- Outputs:
  - RegWEn=grant_valid; AddrD/DataD = granted slot contents.
  - When RegWEn=0, AddrD/DataD hold 0.
  - The granted slot clears at the edge (the register file writes at the same edge) unless reloaded that edge.
- Latency: accepted at edge N → RegWEn visible in cycle N..N+1, written at edge N+1 with no contention; worst case edge N+2.
- Fairness: with both requesters saturated, grants strictly alternate A,M,A,M; neither waits more than 1 extra cycle.
- Simultaneous grant + new request on the same side: slot reloads at the same edge, giving one write per cycle sustained throughput.
- Same destination in both slots: written in grant order; both bits share one PendMask bit, which stays set until neither slot holds that address.
- PendMask is the OR of decoded valid-slot addresses; combinational from registers only.

Optional Feature:
- WBARB_STATS_EN defined:
  - adds out ports ConflictCnt[31:0] and WriteCnt[31:0].
  - ConflictCnt increments each cycle both slots are valid; WriteCnt increments each RegWEn cycle.
  - Both counters wrap at 2^32 and clear on RST.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - XLEN/AW defaults.
  - requester index constants REQ_A=0, REQ_M=1.
  - writeback-request struct {valid, addr, data}.
- One natural sub-module, wb_slot: the holding register with ready logic and x0 filtering, instantiated twice.
- The arbiter and PendMask decode stay in the top.

Test Plan:
- Reset: RST=1 for 2 cycles with AValid=1 → RegWEn=0, PendMask=0, AReady=1 after RST falls.
- Single write: AValid=1, AAddr=5, AData=32'h16 for 1 cycle → next cycle RegWEn=1, AddrD=5, DataD=32'h16, PendMask[5]=1; following cycle RegWEn=0, PendMask=0.
- Contention: A(3,32'hAAAA) and M(7,32'h5555) accepted at the same edge → writes x3 then x7 on consecutive cycles. Repeat → x7 first, because the pointer moved to M.
- Saturation: both Valid=1 for 20 cycles with random data → 20 writes alternating A/M; each slot stalls on alternate cycles. Scoreboard matches every accepted write exactly once.
- x0 filter: MValid=1, MAddr=0, MData=32'hDEAD → MReady=1, no RegWEn, PendMask stays 0.
- Reset mid-operation: both slots full, assert RST → no RegWEn that cycle or after, PendMask=0; with WBARB_STATS_EN defined, both counters read 0.
